// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit.
// MDOp encodings are also used by decode control and the hazard unit.
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True for the multiply class; everything else started is a divide.
    function automatic logic md_is_mult(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// md_calc: purely combinational multiply/divide datapath.
// Ports:
//   A, B      : 32-bit operands (rs, rt)
//   MDOp      : operation code (md_unit_pkg encodings)
//   result    : {hi, lo} 64-bit result for the selected operation
//   div_zero  : high for div/divu with B == 0 (result must not be written)
module md_calc
    import md_unit_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_safe;
    logic        [31:0] mag_a;
    logic        [31:0] mag_b;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] q_s;
    logic        [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'b0, A} * {32'b0, B};

        // Divisor forced nonzero so no divide-by-zero is ever evaluated;
        // the result is discarded via div_zero anyway.
        b_safe = (B == '0) ? 32'd1 : B;

        // Signed divide through magnitudes: avoids the INT_MIN / -1
        // overflow case in the native operator and yields
        // 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0 naturally.
        mag_a = A[31] ? (32'd0 - A) : A;
        mag_b = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        q_mag = mag_a / mag_b;
        r_mag = mag_a % mag_b;
        q_s   = (A[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
        r_s   = A[31] ? (32'd0 - r_mag) : r_mag;

        q_u   = A / b_safe;
        r_u   = A % b_safe;
    end

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        case (MDOp)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                result   = {r_s, q_s};
                div_zero = (B == '0);
            end
            MD_DIVU: begin
                result   = {r_u, q_u};
                div_zero = (B == '0);
            end
            default: begin
                result   = '0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: Execute-stage multiply/divide unit holding HI/LO.
// The full result is computed at Start and held in pending registers while
// Busy counts down MULT_CYCLES / DIV_CYCLES; HI/LO update as Busy drops.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   Start      : one-cycle pulse for mult/multu/div/divu
//   MDOp       : operation code (md_unit_pkg encodings)
//   A, B       : forwarded rs / rt values
//   Busy       : multi-cycle operation in progress
//   HI, LO     : architectural HI / LO registers
//   MDOut      : HI for MFHI, LO for MFLO, else 0 (combinational)
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;

    logic [63:0]        calc_result;
    logic               calc_div_zero;

    md_calc u_calc (
        .A        (A),
        .B        (B),
        .MDOp     (MDOp),
        .result   (calc_result),
        .div_zero (calc_div_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    pend_hi_d = calc_result[63:32];
                    pend_lo_d = calc_result[31:0];
                    pend_wr_d = !calc_div_zero;
                    cnt_d     = md_is_mult(MDOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d   = ST_BUSY;
                end else if (MDOp == MD_MTHI) begin
                    hi_d = A;
                end else if (MDOp == MD_MTLO) begin
                    lo_d = A;
                end
            end
            ST_BUSY: begin
                // Start and MTHI/MTLO are deliberately ignored here.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        MDOut = '0;
        case (MDOp)
            MD_MFHI: MDOut = hi_q;
            MD_MFLO: MDOut = lo_q;
            default: MDOut = '0;
        endcase
    end

    assign Busy = (state_q == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
